fpu_add_sub_sequencer: RTL
==========================

# fpu_add_sub_sequencer

Control FSM for the floating-point add/subtract unit. It accepts an operation through a start/ack handshake, generates the per-stage load enables for the datapath registers, and loads the zero-detect register early. When that flag says the result is zero, the sequence stops there and the normal path is skipped. It sits between the core top level and the add/sub datapath; operand, zero-detect, alignment, adder, normalizer and rounding registers are all loaded only through its enables.

## Interface
- W, 32: operand width (32 single, 64 double); sizes the normalization iteration bound.
- NORM_MAX, W-1: maximum normalization iterations before forced exit.
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- beg_fsm  in  1  start request; sampled only in IDLE.
- ack_fsm  in  1  consumer acknowledge of the result; sampled only in DONE.
- zero_flag  in  1  registered output of the zero-detect unit; valid the cycle after load_zero.
- norm_done  in  1  normalizer reports mantissa MSB in place; sampled in NORM.
- load_ops  out  1  load operand registers.
- load_zero  out  1  load the zero-detect register.
- load_exp  out  1  load exponent compare/difference register.
- load_align  out  1  load aligned (shifted) significand.
- load_add  out  1  load adder result.
- load_norm  out  1  load normalizer one-step shift result.
- load_round  out  1  load rounded result.
- load_result  out  1  load final output register.
- zero_result  out  1  result register must be forced to signed zero; held through DONE.
- norm_ovf  out  1  NORM_MAX reached without norm_done; held through DONE.
- ready  out  1  result valid, waiting for ack_fsm.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD_OPS, ZERO_CHK, EXP_CMP, ALIGN, ADD, NORM, ROUND, DONE.
- All outputs are Moore outputs, decoded from the registered state (plus the sticky flags). There are no combinational input-to-output paths.
- IDLE: outputs 0. When beg_fsm=1, go to LOAD_OPS.
- LOAD_OPS: assert load_ops and load_zero together, then go to ZERO_CHK.
- ZERO_CHK: if zero_flag=1, set sticky zero_result and go to DONE. Otherwise go to EXP_CMP.
- EXP_CMP: load_exp, then go to ALIGN. ALIGN: load_align, then go to ADD. ADD: load_add, then go to NORM.
- NORM: load_norm each cycle. The iteration counter increments each cycle.
  - If norm_done=1, go to ROUND.
  - Otherwise, if the counter equals NORM_MAX-1, set sticky norm_ovf and go to ROUND.
  - Otherwise stay in NORM.
- ROUND: load_round, then go to DONE.
- DONE: ready=1. On entry there is a one-cycle load_result pulse, in the first DONE cycle only. The state holds until ack_fsm=1, then goes to IDLE.
- Sticky flags and the counter are cleared on entry to LOAD_OPS.
- Enables are one-hot: at most one load_* is high per cycle. The only exception is load_ops+load_zero in LOAD_OPS.

## Timing
- Reset: state=IDLE, counter=0, every output 0.
- rst=1 in any state, including mid-NORM or DONE awaiting ack, gives IDLE with all outputs 0 at the next edge. rst has priority over every input.
- Zero path: beg_fsm sampled at edge 0. ready=1 from edge 3 (states LOAD_OPS, ZERO_CHK, DONE).
- Normal path with norm_done on the first NORM cycle: ready=1 from edge 8. Each extra NORM iteration adds 1 cycle. Worst case is 7+NORM_MAX cycles.
- ack_fsm in the same cycle ready first rises is legal: DONE lasts 1 cycle, and IDLE follows.
- beg_fsm asserted outside IDLE is ignored and not queued. beg_fsm and ack_fsm high together in DONE: go to IDLE, and the new start is taken on a later IDLE cycle, not the same one.
- Back-to-back operations: minimum issue interval is 1 cycle in IDLE between operations.

## Structure
- Package fpu_add_ctrl_pkg holds:
  - state enum, binary-encoded, 4 bits;
  - NORM_MAX default;
  - counter width constant, $clog2(W).
- One sub-module, norm_iter_counter: a synchronous clear/enable up-counter with a terminal-count output, used in NORM.
- The FSM next-state logic, the output decode and the sticky flags stay in the top module.

## Test plan
- Reset mid-NORM: beg_fsm, hold norm_done=0 for 3 NORM cycles, then pulse rst. Expect IDLE next edge, all outputs 0, busy=0.
- Zero shortcut: beg_fsm=1 at cycle 0, zero_flag=1 at cycle 2. Expect load_ops/load_zero at cycle 1, ready=1 and zero_result=1 at cycle 3. Expect no load_exp..load_round ever asserted.
- Normal path: zero_flag=0, norm_done=1 on the first NORM cycle. Expect enables in order load_exp(3), load_align(4), load_add(5), load_norm(6), load_round(7), then ready plus a single load_result pulse at 8.
- Normalization overflow: W=32, norm_done held 0. Expect exactly 31 load_norm cycles, then norm_ovf=1 and ready at cycle 38.
- Handshake: hold ack_fsm=0 for 5 cycles in DONE. Expect ready held and load_result high for only 1 cycle. Then ack_fsm=1 with beg_fsm=1: expect IDLE next, then LOAD_OPS the cycle after.
- Ignored start: pulse beg_fsm during ALIGN. Expect no change in sequence or total latency.

Source files
------------

// File: rtl/fpu_add_ctrl_pkg.sv
// Shared types and constants for the floating-point add/subtract control FSM.
package fpu_add_ctrl_pkg;

    // Default operand width (single precision) and the matching normalization bound.
    localparam int W_DEFAULT        = 32;
    localparam int NORM_MAX_DEFAULT = W_DEFAULT - 1;

    // Width of the normalization iteration counter for the default operand width.
    localparam int CNT_W_DEFAULT    = $clog2(W_DEFAULT);

    // Binary-encoded sequencer states; the encoding is visible on the debug port.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD_OPS = 4'd1,
        ST_ZERO_CHK = 4'd2,
        ST_EXP_CMP  = 4'd3,
        ST_ALIGN    = 4'd4,
        ST_ADD      = 4'd5,
        ST_NORM     = 4'd6,
        ST_ROUND    = 4'd7,
        ST_DONE     = 4'd8
    } state_e;

    // Counter width needed to hold iteration indices for a given operand width.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/norm_iter_counter.sv
// Normalization iteration counter: synchronous clear/enable up-counter whose
// terminal-count output flags the last permitted normalization step.
module norm_iter_counter #(
    parameter int WIDTH     = 5,
    parameter int MAX_COUNT = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Terminal value: the counter reads MAX_COUNT-1 during the final allowed iteration.
    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(MAX_COUNT - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear has priority over enable so a new operation always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == TC_VAL);

endmodule

// File: rtl/fpu_add_sub_sequencer.sv
// Control sequencer for the floating-point add/subtract datapath. Issues the
// per-stage load enables, short-circuits to DONE when the operands produce a
// zero result, and bounds the normalization loop.
//
// Handshake: an operation is accepted when beg_fsm is high in IDLE; the
// result is valid while ready is high (DONE) and is retired by ack_fsm high
// in DONE. beg_fsm outside IDLE and ack_fsm outside DONE are ignored.
module fpu_add_sub_sequencer
    import fpu_add_ctrl_pkg::*;
#(
    parameter int W        = W_DEFAULT,
    parameter int NORM_MAX = W - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       beg_fsm,
    input  logic       ack_fsm,
    input  logic       zero_flag,
    input  logic       norm_done,
    output logic       load_ops,
    output logic       load_zero,
    output logic       load_exp,
    output logic       load_align,
    output logic       load_add,
    output logic       load_norm,
    output logic       load_round,
    output logic       load_result,
    output logic       zero_result,
    output logic       norm_ovf,
    output logic       ready,
    output logic       busy,
    output logic [3:0] state_dbg
);

    localparam int CNT_W = cnt_width(W);

    state_e state_q;
    state_e state_d;

    logic zero_q;
    logic zero_d;
    logic ovf_q;
    logic ovf_d;
    logic first_done_q;
    logic first_done_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_val;

    // A new operation is accepted only from IDLE.
    logic start_accept;
    assign start_accept = (state_q == ST_IDLE) && beg_fsm;

    assign cnt_clr = start_accept;
    assign cnt_en  = (state_q == ST_NORM);

    norm_iter_counter #(
        .WIDTH     (CNT_W),
        .MAX_COUNT (NORM_MAX)
    ) u_norm_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt_val),
        .tc    (cnt_tc)
    );

    // State and sticky-flag registers; reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
            first_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            zero_q       <= zero_d;
            ovf_q        <= ovf_d;
            first_done_q <= first_done_d;
        end
    end

    // Next-state logic and sticky-flag updates.
    always_comb begin
        state_d = state_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (beg_fsm) begin
                    state_d = ST_LOAD_OPS;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD_OPS: state_d = ST_ZERO_CHK;
            ST_ZERO_CHK: begin
                if (zero_flag) begin
                    state_d = ST_DONE;
                    zero_d  = 1'b1;
                end else begin
                    state_d = ST_EXP_CMP;
                end
            end
            ST_EXP_CMP:  state_d = ST_ALIGN;
            ST_ALIGN:    state_d = ST_ADD;
            ST_ADD:      state_d = ST_NORM;
            ST_NORM: begin
                if (norm_done) begin
                    state_d = ST_ROUND;
                end else if (cnt_tc) begin
                    state_d = ST_ROUND;
                    ovf_d   = 1'b1;
                end
            end
            ST_ROUND:    state_d = ST_DONE;
            ST_DONE: begin
                if (ack_fsm) begin
                    state_d = ST_IDLE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
        // load_result fires only in the cycle DONE is entered.
        first_done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // Moore output decode from the registered state and sticky flags.
    always_comb begin
        load_ops    = 1'b0;
        load_zero   = 1'b0;
        load_exp    = 1'b0;
        load_align  = 1'b0;
        load_add    = 1'b0;
        load_norm   = 1'b0;
        load_round  = 1'b0;
        load_result = 1'b0;
        zero_result = 1'b0;
        norm_ovf    = 1'b0;
        ready       = 1'b0;
        case (state_q)
            ST_LOAD_OPS: begin
                load_ops  = 1'b1;
                load_zero = 1'b1;
            end
            ST_EXP_CMP: load_exp   = 1'b1;
            ST_ALIGN:   load_align = 1'b1;
            ST_ADD:     load_add   = 1'b1;
            ST_NORM:    load_norm  = 1'b1;
            ST_ROUND:   load_round = 1'b1;
            ST_DONE: begin
                ready       = 1'b1;
                load_result = first_done_q;
                zero_result = zero_q;
                norm_ovf    = ovf_q;
            end
            default: ;
        endcase
        busy = (state_q != ST_IDLE);
    end

    assign state_dbg = state_q;

endmodule
